mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single memory port between the instruction-fetch requester and the load/store requester of the multi-cycle core. Each requester uses a valid/ready handshake. The block serializes accepted requests onto one downstream req/gnt/rvalid memory interface and returns each response to its owner. It sits between the control unit's fetch/memory sequencing and the memory model, with one transaction outstanding at a time.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width (package constant)
MAX_D_BURST, 4, max consecutive data grants while a fetch is waiting (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
if_req_valid  in  1  fetch request valid
if_req_ready  out  1  fetch request accepted this cycle
if_addr  in  ADDR_WIDTH  fetch address
if_resp_valid  out  1  fetch response, 1-cycle pulse
if_resp_err  out  1  fetch misaligned, qualified by if_resp_valid
if_rdata  out  DATA_WIDTH  fetched word
d_req_valid  in  1  data request valid
d_req_ready  out  1  data request accepted this cycle
d_addr  in  ADDR_WIDTH  data address
d_we  in  1  store when 1
d_wdata  in  DATA_WIDTH  store data
d_size  in  2  00 byte, 01 half, 10 word
d_sign  in  1  sign-extend load
d_resp_valid  out  1  data response, 1-cycle pulse (loads and stores)
d_resp_err  out  1  data misaligned, qualified by d_resp_valid
d_rdata  out  DATA_WIDTH  load data
mem_req  out  1  downstream request
mem_gnt  in  1  downstream accepted request
mem_addr  out  ADDR_WIDTH  registered address
mem_we  out  1  registered write enable
mem_wdata  out  DATA_WIDTH  registered write data
mem_size  out  2  registered size
mem_sign  out  1  registered sign
mem_rvalid  in  1  downstream response valid
mem_rdata  in  DATA_WIDTH  downstream read data
busy  out  1  state != IDLE

Behaviour:
- Reset, asynchronous: state IDLE, owner NONE, starvation counter 0, all mem_* outputs 0, all *_ready/*_resp_* outputs 0.
- Reset asserted mid-transaction drops the transaction; no response is issued. Requesters reissue.
- States: IDLE, REQ, RESP, ERR.
- IDLE:
  - Grant is combinational. The selected port's ready equals its valid; at most one ready is high per cycle.
  - On acceptance, latch the request into registers:
    - fetch: we=0, size=10, sign=0, wdata=0
    - data: the d_* fields
  - Misaligned request (half with addr[0]=1; word or fetch with addr[1:0]!=0) goes to ERR. Otherwise go to REQ.
- REQ: mem_req=1 with the registered fields. mem_gnt=1 moves to RESP; mem_req drops the following cycle. No timeout.
- RESP: mem_req=0. When mem_rvalid=1:
  - the owner's resp_valid=1 and rdata=mem_rdata, combinational pass-through in the same cycle;
  - the non-owner's rdata is 0;
  - go to IDLE.
- ERR: one cycle. The owner's resp_valid=1, resp_err=1, rdata=0. Then IDLE. The memory is never touched.
- mem_gnt outside REQ and mem_rvalid outside RESP are ignored.
- Latency: accept at cycle T, mem_req at T+1. With gnt at T+1 and rvalid at T+2, the response is at T+2 and the next acceptance is possible at T+3. An error response is at T+1.
- Arbitration: data has priority over fetch, with a starvation guard.
  - On each data grant with if_req_valid=1, the counter increments (saturating at MAX_D_BURST).
  - On a data grant with if_req_valid=0, or on any fetch grant, the counter clears.
  - When counter==MAX_D_BURST and both ports are valid, fetch wins.
- Requester inputs are sampled only on the acceptance cycle. Changes while not ready have no effect.

Decomposition:
- Shared package _riscv_defines gets:
  - arb_state_t {IDLE, REQ, RESP, ERR}
  - arb_owner_t {OWN_NONE, OWN_IF, OWN_D}
  - MEM_SIZE_B/H/W constants, reused by control_unit
- Sub-module mem_arb_grant: both valids plus the starvation counter in, one-hot grant out. The counter is registered inside it and advanced by an accept strobe.

Test Plan:
- Fetch only at if_addr=0x100; mem_gnt the same cycle, rvalid next cycle with 0xDEADBEEF -> if_req_ready at T, mem_req at T+1 with mem_addr=0x100, mem_we=0, mem_size=10, if_resp_valid with if_rdata=0xDEADBEEF at T+2, busy low at T+3.
- Both valid at cycle 0 -> data granted first. With both held continuously and MAX_D_BURST=4: grant order D,D,D,D,IF,D...
- Store d_addr=0x202, size=01, wdata=0x1234 -> mem_we=1, mem_size=01, mem_wdata=0x1234; d_resp_valid on rvalid, d_resp_err=0.
- Misaligned load d_addr=0x203, size=10 -> mem_req never rises; d_resp_valid=1, d_resp_err=1, d_rdata=0 one cycle after acceptance.
- mem_gnt held low 5 cycles -> mem_req and mem_addr stable throughout. A spurious mem_rvalid in REQ produces no response.
- rst_n pulled low in RESP -> all outputs 0 immediately. After release, a late mem_rvalid produces no response, and a new fetch proceeds normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types and constants for the memory-port arbiter.
//               This package holds the arbiter state and owner encodings and
//               the memory access size codes that the control unit also uses.
//               It also provides the alignment check that the arbiter
//               applies when it accepts a request.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_t;

    // A half access needs an even address. A word access needs a
    // word-aligned address. A byte access is always aligned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lsb);
        logic r;
        r = 1'b0;
        if (size == MEM_SIZE_H)
            r = addr_lsb[0];
        else if (size == MEM_SIZE_W)
            r = (addr_lsb != 2'b00);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_grant
// Description : One-hot grant between the fetch port and the data port.
//               Data has priority. A counter counts consecutive data grants
//               taken while a fetch is waiting. When that counter reaches
//               MAX_D_BURST, the fetch port wins the next contested grant.
// Ports       : clk, rst_n           - clock, async active-low reset
//               if_valid, d_valid    - requester valids
//               enable               - arbiter able to accept (IDLE)
//               accept               - a grant was taken this cycle
//               grant_if, grant_d    - one-hot grant (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_grant #(
    parameter int MAX_D_BURST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_valid,
    input  logic d_valid,
    input  logic enable,
    input  logic accept,
    output logic grant_if,
    output logic grant_d
);

    localparam logic [3:0] c_max_burst = 4'(MAX_D_BURST);

    logic [3:0] r_burst_cnt;
    logic       w_fetch_turn;

    assign w_fetch_turn = (r_burst_cnt == c_max_burst) && if_valid;
    assign grant_d      = enable && d_valid && !w_fetch_turn;
    assign grant_if     = enable && if_valid && !grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_cnt <= 4'd0;
        end else if (accept) begin
            // Only a data grant taken over a waiting fetch extends the burst.
            if (grant_d && if_valid) begin
                if (r_burst_cnt != c_max_burst)
                    r_burst_cnt <= r_burst_cnt + 4'd1;
            end else begin
                r_burst_cnt <= 4'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Puts the fetch requester and the load/store requester onto
//               one req/gnt/rvalid memory port, one transaction at a time.
//               Each response goes back to the requester that owns it.
//               A misaligned request gets an error response and never
//               reaches the memory.
// Ports       : clk, rst_n                    - clock, async active-low reset
//               if_req_* / if_addr / if_resp_*  - fetch requester
//               d_req_* / d_* / d_resp_*        - load/store requester
//               mem_*                           - downstream memory port
//               busy                            - arbiter not idle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int MAX_D_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_resp_valid,
    output logic                  if_resp_err,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_we,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [1:0]            d_size,
    input  logic                  d_sign,
    output logic                  d_resp_valid,
    output logic                  d_resp_err,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            mem_size,
    output logic                  mem_sign,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    arb_state_t r_state, w_state_nxt;
    arb_owner_t r_owner;

    logic w_grant_if, w_grant_d, w_accept, w_misaligned, w_enable;

    // Gating with rst_n keeps both readys low while reset is held.
    assign w_enable = rst_n && (r_state == IDLE);
    assign w_accept = w_grant_if || w_grant_d;

    mem_arb_grant #(
        .MAX_D_BURST (MAX_D_BURST)
    ) u_grant (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_valid (if_req_valid),
        .d_valid  (d_req_valid),
        .enable   (w_enable),
        .accept   (w_accept),
        .grant_if (w_grant_if),
        .grant_d  (w_grant_d)
    );

    assign if_req_ready = w_grant_if;
    assign d_req_ready  = w_grant_d;
    assign busy         = (r_state != IDLE);
    assign mem_req      = (r_state == REQ);

    assign w_misaligned = w_grant_d ? is_misaligned(d_size, d_addr[1:0])
                                    : is_misaligned(MEM_SIZE_W, if_addr[1:0]);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_misaligned ? ERR : REQ;
            REQ:     if (mem_gnt) w_state_nxt = RESP;
            RESP:    if (mem_rvalid) w_state_nxt = IDLE;
            ERR:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_owner   <= OWN_NONE;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_size  <= 2'b00;
            mem_sign  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                if (w_grant_d) begin
                    r_owner   <= OWN_D;
                    mem_addr  <= d_addr;
                    mem_we    <= d_we;
                    mem_wdata <= d_wdata;
                    mem_size  <= d_size;
                    mem_sign  <= d_sign;
                end else begin
                    r_owner   <= OWN_IF;
                    mem_addr  <= if_addr;
                    mem_we    <= 1'b0;
                    mem_wdata <= '0;
                    mem_size  <= MEM_SIZE_W;
                    mem_sign  <= 1'b0;
                end
            end else if (w_state_nxt == IDLE) begin
                r_owner <= OWN_NONE;
            end
        end
    end

    // Responses are combinational. Read data passes through in the same
    // cycle as mem_rvalid. The requester that does not own the response
    // sees zero data.
    always_comb begin
        if_resp_valid = 1'b0;
        if_resp_err   = 1'b0;
        if_rdata      = '0;
        d_resp_valid  = 1'b0;
        d_resp_err    = 1'b0;
        d_rdata       = '0;
        if (r_state == RESP && mem_rvalid) begin
            if (r_owner == OWN_IF) begin
                if_resp_valid = 1'b1;
                if_rdata      = mem_rdata;
            end else if (r_owner == OWN_D) begin
                d_resp_valid = 1'b1;
                d_rdata      = mem_rdata;
            end
        end else if (r_state == ERR) begin
            if (r_owner == OWN_IF) begin
                if_resp_valid = 1'b1;
                if_resp_err   = 1'b1;
            end else if (r_owner == OWN_D) begin
                d_resp_valid = 1'b1;
                d_resp_err   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed bench for mem_port_arbiter. Each test drives inputs
//               just after a rising edge and checks the outputs before the
//               next rising edge. All expected values are worked out by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req_valid, d_req_ready, d_we, d_sign, d_resp_valid, d_resp_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size, mem_size;
    logic        mem_req, mem_gnt, mem_we, mem_sign, mem_rvalid, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .MAX_D_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_resp_err(if_resp_err), .if_rdata(if_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_wdata(d_wdata), .d_size(d_size), .d_sign(d_sign),
        .d_resp_valid(d_resp_valid), .d_resp_err(d_resp_err), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_sign(mem_sign),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        rst_n = 1'b0;
        if_req_valid = 1'b1; if_addr = 32'h0;
        d_req_valid = 1'b0; d_addr = 32'h0; d_we = 1'b0; d_wdata = 32'h0;
        d_size = 2'b00; d_sign = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // Reset state; ready stays low even with a valid fetch present
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_ready", {31'd0, if_req_ready}, 32'd0);
        if_req_valid = 1'b0;
        rst_n = 1'b1;

        // Fetch at 0x100, gnt immediately, rvalid next cycle
        tick();
        if_req_valid = 1'b1; if_addr = 32'h100; settle();
        chk("f_if_ready", {31'd0, if_req_ready}, 32'd1);
        chk("f_d_ready", {31'd0, d_req_ready}, 32'd0);
        tick();
        if_req_valid = 1'b0; if_addr = 32'hFFFF_FFFF; mem_gnt = 1'b1; settle();
        chk("f_mem_req", {31'd0, mem_req}, 32'd1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_we", {31'd0, mem_we}, 32'd0);
        chk("f_mem_size", {30'd0, mem_size}, 32'd2);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; settle();
        chk("f_mem_req_drop", {31'd0, mem_req}, 32'd0);
        chk("f_resp_valid", {31'd0, if_resp_valid}, 32'd1);
        chk("f_rdata", if_rdata, 32'hDEADBEEF);
        chk("f_d_rdata_zero", d_rdata, 32'd0);
        chk("f_d_resp_valid", {31'd0, d_resp_valid}, 32'd0);
        tick();
        mem_rvalid = 1'b0; settle();
        chk("f_busy_low", {31'd0, busy}, 32'd0);
        chk("f_resp_pulse", {31'd0, if_resp_valid}, 32'd0);

        // Both held valid: expected grant order D,D,D,D,IF,D
        if_req_valid = 1'b1; if_addr = 32'h200;
        d_req_valid = 1'b1; d_addr = 32'h300; d_size = 2'b10; d_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk($sformatf("arb_d_ready_%0d", i), {31'd0, d_req_ready}, {31'd0, exp_d[i]});
            chk($sformatf("arb_if_ready_%0d", i), {31'd0, if_req_ready}, {31'd0, ~exp_d[i]});
            tick();
            mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1000 + i;
            settle();
            chk($sformatf("arb_dresp_%0d", i), {31'd0, d_resp_valid}, {31'd0, exp_d[i]});
            tick();
            mem_rvalid = 1'b0;
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;

        // Half store to 0x202
        d_req_valid = 1'b1; d_addr = 32'h202; d_we = 1'b1; d_size = 2'b01;
        d_wdata = 32'h1234; settle();
        chk("st_ready", {31'd0, d_req_ready}, 32'd1);
        tick();
        d_req_valid = 1'b0; d_wdata = 32'h0; settle();
        chk("st_mem_we", {31'd0, mem_we}, 32'd1);
        chk("st_mem_size", {30'd0, mem_size}, 32'd1);
        chk("st_mem_wdata", mem_wdata, 32'h1234);
        chk("st_mem_addr", mem_addr, 32'h202);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0; settle();
        chk("st_resp_valid", {31'd0, d_resp_valid}, 32'd1);
        chk("st_resp_err", {31'd0, d_resp_err}, 32'd0);
        tick();
        mem_rvalid = 1'b0;

        // Misaligned word load to 0x203
        d_req_valid = 1'b1; d_addr = 32'h203; d_we = 1'b0; d_size = 2'b10;
        mem_rdata = 32'hAAAA_5555; settle();
        chk("mis_ready", {31'd0, d_req_ready}, 32'd1);
        tick();
        d_req_valid = 1'b0; settle();
        chk("mis_mem_req", {31'd0, mem_req}, 32'd0);
        chk("mis_resp_valid", {31'd0, d_resp_valid}, 32'd1);
        chk("mis_resp_err", {31'd0, d_resp_err}, 32'd1);
        chk("mis_rdata", d_rdata, 32'd0);
        tick();
        chk("mis_mem_req2", {31'd0, mem_req}, 32'd0);
        chk("mis_busy", {31'd0, busy}, 32'd0);
        chk("mis_resp_pulse", {31'd0, d_resp_valid}, 32'd0);

        // Grant stall for 5 cycles with a spurious rvalid in REQ
        if_req_valid = 1'b1; if_addr = 32'h400; settle();
        chk("stall_accept", {31'd0, if_req_ready}, 32'd1);
        tick();
        if_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_rvalid = (i == 2);
            settle();
            chk($sformatf("stall_req_%0d", i), {31'd0, mem_req}, 32'd1);
            chk($sformatf("stall_addr_%0d", i), mem_addr, 32'h400);
            chk($sformatf("stall_noresp_%0d", i), {31'd0, if_resp_valid}, 32'd0);
            tick();
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D; settle();
        chk("stall_resp", if_rdata, 32'h0BAD_F00D);
        tick();
        mem_rvalid = 1'b0;

        // Reset in RESP, then a late rvalid, then a fresh fetch
        if_req_valid = 1'b1; if_addr = 32'h500;
        tick();
        if_req_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; settle();
        chk("rr_in_resp", {31'd0, busy}, 32'd1);
        rst_n = 1'b0; settle();
        chk("rr_busy", {31'd0, busy}, 32'd0);
        chk("rr_mem_addr", mem_addr, 32'd0);
        chk("rr_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_5A5A; settle();
        chk("rr_late_if", {31'd0, if_resp_valid}, 32'd0);
        chk("rr_late_d", {31'd0, d_resp_valid}, 32'd0);
        chk("rr_late_rdata", if_rdata, 32'd0);
        tick();
        mem_rvalid = 1'b0;
        if_req_valid = 1'b1; if_addr = 32'h600; settle();
        chk("rr_new_ready", {31'd0, if_req_ready}, 32'd1);
        tick();
        if_req_valid = 1'b0; mem_gnt = 1'b1; settle();
        chk("rr_new_addr", mem_addr, 32'h600);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001; settle();
        chk("rr_new_resp", {31'd0, if_resp_valid}, 32'd1);
        chk("rr_new_rdata", if_rdata, 32'hCAFE_0001);
        tick();
        mem_rvalid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
